leaf_out_packetizer: RTL
========================

LEAF_OUT_PACKETIZER -- requirements
Module: leaf_out_packetizer

Interface
REQ-001 The block SHALL have parameter PACKET_BITS, default 49, BFT packet width.
REQ-002 The block SHALL have parameter PAYLOAD_BITS, default 32, user word width.
REQ-003 The block SHALL have parameter NUM_LEAF_BITS, default 5, destination leaf field width.
REQ-004 The block SHALL have parameter NUM_PORT_BITS, default 4, destination port field width.
REQ-005 The block SHALL have parameter NUM_ADDR_BITS, default 7, per-port sequence field width.
REQ-006 The block SHALL have parameter NUM_OUT_PORTS, default 6, number of user output ports.
REQ-007 The block SHALL have parameter CREDIT_BITS, default 8, per-port credit counter width.
REQ-008 The block SHALL have one clock and a synchronous, active-high reset: clk, input, 1, sole clock; reset, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have din_leaf_user2interface, input, NUM_OUT_PORTS*PAYLOAD_BITS, user words; port 1 in the low slice.
REQ-010 The block SHALL have vld_user2interface, input, NUM_OUT_PORTS, per-port word valid.
REQ-011 The block SHALL have ack_interface2user, output, NUM_OUT_PORTS, per-port accept; a word transfers in any cycle where vld and ack are both high.
REQ-012 The block SHALL have cfg_vld, input, 1, config write strobe.
REQ-013 The block SHALL have cfg_port, input, 3, zero-based target port index.
REQ-014 The block SHALL have cfg_dest_leaf, input, NUM_LEAF_BITS, destination leaf.
REQ-015 The block SHALL have cfg_dest_port, input, NUM_PORT_BITS, destination port.
REQ-016 The block SHALL have credit_vld, input, 1, credit-return strobe.
REQ-017 The block SHALL have credit_port, input, 3, zero-based port index for credit_vld.
REQ-018 The block SHALL have credit_add, input, CREDIT_BITS, credits returned.
REQ-019 The block SHALL have dout_leaf_interface2bft, output, PACKET_BITS, registered packet; bit 48 is the valid bit.
REQ-020 The block SHALL have dout_ready, input, 1, BFT accepts the held packet this cycle.

Function
REQ-021 Packet format SHALL be [48]=1, [47:43]=dest leaf, [42:39]=dest port, [38:32]=sequence, [31:0]=payload.
REQ-022 A cfg_vld write SHALL store leaf/port for cfg_port and set that port's configured flag; cfg_port >= NUM_OUT_PORTS SHALL be ignored.
REQ-023 A port SHALL be eligible when vld high, configured flag set, and credit > 0.
REQ-024 The output register SHALL be free when bit 48 = 0 or dout_ready = 1.
REQ-025 When the output register is free, exactly one eligible port SHALL be granted, chosen round-robin starting at the port after the last granted (port 1 after reset).
REQ-026 ack SHALL be combinational, one-hot or zero, and high only for the granted port.
REQ-027 A granted word SHALL appear on dout_leaf_interface2bft on the next clk edge (latency 1), with the port's current sequence value.
REQ-028 The output register SHALL hold unchanged while bit 48 = 1 and dout_ready = 0.
REQ-029 If dout_ready = 1 and no grant occurs, bit 48 SHALL clear next cycle.
REQ-030 On grant, the port's sequence SHALL increment modulo 2^NUM_ADDR_BITS (127 wraps to 0) and its credit SHALL decrement by 1.
REQ-031 credit_vld SHALL add credit_add to the credit of credit_port, saturating at 2^CREDIT_BITS-1; an out-of-range port SHALL be ignored.
REQ-032 A simultaneous grant and credit return on the same port SHALL apply the net value credit + credit_add - 1, saturated.
REQ-033 A config write to a port SHALL take effect for grants from the next cycle; the same-cycle grant SHALL use the old fields.
REQ-034 A port with credit 0 SHALL never be acked, regardless of vld.

Reset
REQ-035 While reset is high at a clk edge: the output register SHALL be cleared to 0; every credit SHALL be set to 64; every sequence SHALL be set to 0; every configured flag SHALL be cleared; and the round-robin pointer SHALL be set to port 1.
REQ-036 While reset is high, ack_interface2user SHALL be 0.
REQ-037 Reset asserted mid-transfer SHALL discard the held packet without waiting for dout_ready.

Verification
REQ-038 Configure port 1 to leaf 3, port 2, with dout_ready = 1 and vld_1 = 1 holding payload 0xDEADBEEF. Required response: ack_1 = 1 the same cycle, and dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF} the next cycle.
REQ-039 Hold all six ports configured and valid with dout_ready = 1. Required response: grant order 1,2,3,4,5,6,1, with one packet per cycle.
REQ-040 Hold dout_ready = 0 for 5 cycles with a packet held and vld_2 = 1. Required response: dout is stable, ack_2 = 0 throughout, and ack_2 rises in the cycle dout_ready = 1.
REQ-041 Send 64 words on port 1 with no credit return. Required response: the 65th word gets no ack. Then apply credit_vld with port 0 and add 64. Required response: ack resumes the next cycle.
REQ-042 Send 130 words on port 3 while returning credit. Required response: sequence runs 0..127 then 0,1.
REQ-043 Assert reset while a packet is held with dout_ready = 0. Required response: dout = 0 the next cycle, credits read back as 64, and no ack is given until the port is configured again.

Source files
------------

// File: rtl/leaf_out_packetizer.sv
// Leaf-side output packetizer: round-robin arbitrates per-port user words into BFT packets,
// tagging each with the port's configured destination and a per-port sequence, under per-port credit.
module leaf_out_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 6,
  parameter int CREDIT_BITS   = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_vld,
  input  logic [2:0]                              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
  input  logic                                    credit_vld,
  input  logic [2:0]                              credit_port,
  input  logic [CREDIT_BITS-1:0]                  credit_add,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    dout_ready
);

  localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(64);

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [NUM_OUT_PORTS-1:0] cfgd_q, cfgd_d;
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d    [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] elig, cfg_hit, crd_hit, grant;
  logic                     out_free, grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [PACKET_BITS-1:0]   grant_pkt;

  // Credit update: add returned credit, subtract a consumed one, clamp at all-ones.
  function automatic logic [CREDIT_BITS-1:0] credit_next(input logic [CREDIT_BITS-1:0] cur,
                                                         input logic [CREDIT_BITS-1:0] add,
                                                         input logic                   take);
    logic [CREDIT_BITS:0] sum;
    sum = {1'b0, cur} + {1'b0, add} - {{CREDIT_BITS{1'b0}}, take};
    if (sum[CREDIT_BITS]) return '1;
    return sum[CREDIT_BITS-1:0];
  endfunction

  assign out_free = !dout_q[PACKET_BITS-1] || dout_ready;

  always_comb begin
    elig    = '0;
    cfg_hit = '0;
    crd_hit = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i]    = vld_user2interface[i] && cfgd_q[i] && (credit_q[i] != '0);
      cfg_hit[i] = cfg_vld && (int'(cfg_port) == i);
      crd_hit[i] = credit_vld && (int'(credit_port) == i);
    end
  end

  // Round robin: scan from the pointer to the top, then wrap to the ports below it.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    if (out_free && !reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (!grant_vld && elig[i] && (i >= int'(ptr_q))) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(i);
          grant[i]  = 1'b1;
        end
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (!grant_vld && elig[i] && (i < int'(ptr_q))) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(i);
          grant[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        grant_pkt = {1'b1, leaf_q[i], dport_q[i], seq_q[i],
                     din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  assign ack_interface2user = grant;

  always_comb begin
    dout_d = dout_q;
    if (out_free) begin
      dout_d = grant_vld ? grant_pkt : '0;
    end
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
    cfgd_d = cfgd_q | cfg_hit;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      seq_d[i]    = seq_q[i] + NUM_ADDR_BITS'(grant[i]);
      credit_d[i] = credit_next(credit_q[i], crd_hit[i] ? credit_add : '0, grant[i]);
    end
  end

  // Output register and per-port control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      ptr_q  <= '0;
      cfgd_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CREDIT_INIT;
        seq_q[i]    <= '0;
      end
    end else begin
      dout_q <= dout_d;
      ptr_q  <= ptr_d;
      cfgd_q <= cfgd_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        seq_q[i]    <= seq_d[i];
      end
    end
  end

  // Destination fields carry no reset; the configured flag gates their use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (cfg_hit[i]) begin
        leaf_q[i]  <= cfg_dest_leaf;
        dport_q[i] <= cfg_dest_port;
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule
